nand_gate_unit: RTL and testbench

Bitwise two-input NAND primitive with a registered, valid-qualified output stage and a small truth-table coverage monitor. It sits at the leaf level of the logic-primitive library, where designs need either a pure combinational NAND or a clocked NAND with pipeline alignment. The combinational path y preserves the classic a/b/y gate behaviour; the registered path adds one cycle of latency.

---
 rtl/nand_gate_unit_pkg.sv | 16 +
 rtl/nand_lane.sv | 11 +
 rtl/nand_gate_unit.sv | 68 ++++++
 tb/tb_nand_gate_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nand_gate_unit_pkg.sv
// Shared constants and helpers for the nand_gate_unit primitive.
package nand_gate_unit_pkg;

   // Reset value of the registered output: NAND of 0,0 is all-ones. Sized for
   // the widest legal lane count; users slice down to WIDTH.
   localparam logic [63:0] NAND_RST_VAL = '1;

   // Coverage vector with every lane-0 input pair observed.
   localparam logic [3:0] COV_ALL = 4'b1111;

   // Coverage bit index for a lane-0 input pair: {a, b}.
   function automatic logic [1:0] cov_idx(input logic a0, input logic b0);
      return {a0, b0};
   endfunction

endpackage

// File: rtl/nand_lane.sv
// Single-bit combinational NAND, the leaf cell replicated per lane.
module nand_lane (
   input  logic a,
   input  logic b,
   output logic y
);

   // Pure combinational gate; X on either input propagates naturally.
   assign y = ~(a & b);

endmodule

// File: rtl/nand_gate_unit.sv
// Bitwise NAND with a combinational output, a registered valid-qualified
// output, and a sticky lane-0 truth-table coverage monitor.
module nand_gate_unit
   import nand_gate_unit_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   input  logic             clr,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             out_valid,
   output logic [3:0]       cov,
   output logic             cov_full,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // One NAND cell per lane; y is valid regardless of clock or reset.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      nand_lane u_lane (
         .a (a[i]),
         .b (b[i]),
         .y (y[i])
      );
   end

   // Registered result: capture on in_valid, hold otherwise.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q       <= NAND_RST_VAL[WIDTH-1:0];
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y_q <= y;
         end
      end
   end

   // Coverage and saturating sample counter; clr wins over a same-cycle sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cov        <= '0;
         sample_cnt <= '0;
      end else if (clr) begin
         cov        <= '0;
         sample_cnt <= '0;
      end else if (in_valid) begin
         cov[cov_idx(a[0], b[0])] <= 1'b1;
         if (sample_cnt != CNT_MAX) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
         end
      end
   end

   // Full coverage flag derived directly from the sticky vector.
   assign cov_full = (cov == COV_ALL);

endmodule

// File: tb/tb_nand_gate_unit.sv
// Scoreboard bench: stimulus pushes expected registered results, a monitor
// pops and compares whenever out_valid is presented.
module tb_nand_gate_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       in_valid;
   logic       a1, b1;
   logic [7:0] a8, b8;

   logic        y_a, yq_a, ov_a, cf_a;
   logic [3:0]  cov_a;
   logic [15:0] cnt_a;
   logic        y_s, yq_s, ov_s, cf_s;
   logic [3:0]  cov_s;
   logic [1:0]  cnt_s;
   logic [7:0]  y_w, yq_w;
   logic        ov_w, cf_w;
   logic [3:0]  cov_w;
   logic [15:0] cnt_w;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       y1;
      logic [7:0] y8;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   nand_gate_unit #(.WIDTH(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid), .clr(clr),
      .y(y_a), .y_q(yq_a), .out_valid(ov_a), .cov(cov_a), .cov_full(cf_a),
      .sample_cnt(cnt_a)
   );

   nand_gate_unit #(.WIDTH(1), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid), .clr(clr),
      .y(y_s), .y_q(yq_s), .out_valid(ov_s), .cov(cov_s), .cov_full(cf_s),
      .sample_cnt(cnt_s)
   );

   nand_gate_unit #(.WIDTH(8), .CNT_W(16)) dut_w (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid), .clr(clr),
      .y(y_w), .y_q(yq_w), .out_valid(ov_w), .cov(cov_w), .cov_full(cf_w),
      .sample_cnt(cnt_w)
   );

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one valid sample (takes effect at the next edge) and queue its result.
   task automatic issue(input logic ia, input logic ib, input logic [7:0] ia8,
                        input logic [7:0] ib8, input logic ey1,
                        input logic [7:0] ey8);
      a1 = ia; b1 = ib; a8 = ia8; b8 = ib8;
      in_valid = 1'b1;
      sb_q.push_back('{y1: ey1, y8: ey8});
   endtask

   // Monitor: pop and compare every presented registered result.
   always @(negedge clk) begin
      if (ov_a === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 16'(ov_a), 16'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_yq_w1",      16'(yq_a), 16'(e.y1));
            check("sb_yq_sat",     16'(yq_s), 16'(e.y1));
            check("sb_yq_w8",      16'(yq_w), 16'(e.y8));
            check("sb_ov_w8",      16'(ov_w), 16'h1);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // Directed vectors for the coverage/saturation sequence.
   logic       v_a [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic       v_b [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] v_a8[5] = '{8'h00, 8'hFF, 8'hF0, 8'hAA, 8'hFF};
   logic [7:0] v_b8[5] = '{8'h00, 8'h0F, 8'hCC, 8'h55, 8'hFF};
   logic       v_y [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [7:0] v_y8[5] = '{8'hFF, 8'hF0, 8'h3F, 8'hFF, 8'h00};
   logic [3:0] v_cov[5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
      a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      #1;
      check("rst_yq_w1",  16'(yq_a),  16'h1);
      check("rst_yq_w8",  16'(yq_w),  16'hFF);
      check("rst_ov",     16'(ov_a),  16'h0);
      check("rst_cov",    16'(cov_a), 16'h0);
      check("rst_cnt",    cnt_a,      16'h0);

      // Combinational truth table, exercised while still in reset.
      for (int i = 0; i < 4; i++) begin
         a1 = v_a[i]; b1 = v_b[i];
         #10;
         check($sformatf("comb_y a=%0b b=%0b", a1, b1), 16'(y_a), 16'(v_y[i]));
      end
      a8 = 8'hF0; b8 = 8'hCC;
      #1;
      check("comb_y_w8", 16'(y_w), 16'h3F);

      @(negedge clk);
      rst = 1'b0;

      // Registered path: single pulse then an idle cycle.
      step();
      issue(1'b1, 1'b1, 8'hF0, 8'hCC, 1'b0, 8'h3F);
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      check("idle_ov",      16'(ov_a), 16'h0);
      check("idle_yq_held", 16'(yq_a), 16'h0);
      check("idle_yq_w8",   16'(yq_w), 16'h3F);

      // Clear, then walk the four lane-0 combinations plus one extra sample.
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_cov", 16'(cov_a), 16'h0);
      for (int i = 0; i < 5; i++) begin
         issue(v_a[i], v_b[i], v_a8[i], v_b8[i], v_y[i], v_y8[i]);
         step();
         check($sformatf("cov_step%0d", i), 16'(cov_a), 16'(v_cov[i]));
         check($sformatf("cov_full_step%0d", i), 16'(cf_a),
               16'(v_cov[i] == 4'b1111));
         if (i == 3) check("cnt_after4", cnt_a, 16'd4);
      end
      check("cnt_after5",   cnt_a,      16'd5);
      check("cnt_sat",      16'(cnt_s), 16'd3);

      // clr together with in_valid: counters clear, y_q still updates.
      issue(1'b0, 1'b1, 8'h3C, 8'h0F, 1'b1, 8'hF3);
      clr = 1'b1;
      step();
      clr = 1'b0;
      in_valid = 1'b0;
      check("clr_valid_cov",     16'(cov_a), 16'h0);
      check("clr_valid_cnt",     cnt_a,      16'h0);
      check("clr_valid_cnt_sat", 16'(cnt_s), 16'h0);
      check("clr_valid_yq",      16'(yq_a),  16'h1);

      // Async reset between edges while streaming.
      step();
      issue(1'b1, 1'b1, 8'hFF, 8'h0F, 1'b0, 8'hF0);
      step();
      issue(1'b1, 1'b0, 8'h81, 8'h81, 1'b1, 8'h7E);
      #2;
      rst = 1'b1;
      sb_q.delete();
      #1;
      check("arst_yq_w1",  16'(yq_a),  16'h1);
      check("arst_yq_w8",  16'(yq_w),  16'hFF);
      check("arst_ov",     16'(ov_a),  16'h0);
      check("arst_cov",    16'(cov_a), 16'h0);
      check("arst_cnt",    cnt_a,      16'h0);
      check("arst_y_w1",   16'(y_a),   16'h1);
      check("arst_y_w8",   16'(y_w),   16'h7E);
      in_valid = 1'b0;
      step();
      @(negedge clk);
      rst = 1'b0;

      // First edge after reset release behaves as a normal cycle.
      issue(1'b1, 1'b1, 8'hF0, 8'hCC, 1'b0, 8'h3F);
      step();
      in_valid = 1'b0;
      check("post_rst_cnt", cnt_a, 16'd1);
      step();
      step();
      check("sb_drained", 16'(sb_q.size()), 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
